// File: rtl/alu_op_sequencer.sv
// Issue side of the ALUOp interface: maps opcode/funct to an ALUOp code and holds it per op.
// Latency: ISSUE one cycle after start, COMPLETE after 1 or 2 held cycles, ERR one cycle after start.
// Backpressure: start is ignored while busy; a start seen in IDLE/COMPLETE/ERR launches the next op.
module alu_op_sequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       lt,
  input  logic       gt,
  input  logic       UC_control,
  input  logic [1:0] UC_op,
  output logic [3:0] ALUOp,
  output logic       busy,
  output logic       done,
  output logic       alu_out_write,
  output logic       branch_taken,
  output logic       illegal,
  output logic       proto_err
);

  localparam logic [3:0] NO_OP     = 4'd0;
  localparam logic [3:0] ADD       = 4'd1;
  localparam logic [3:0] SUB       = 4'd2;
  localparam logic [3:0] AND_OP    = 4'd3;
  localparam logic [3:0] SHIFT_L1  = 4'd5;
  localparam logic [3:0] SHIFT_L2  = 4'd6;
  localparam logic [3:0] SHIFT_R   = 4'd7;
  localparam logic [3:0] SHIFT_RA1 = 4'd8;
  localparam logic [3:0] SHIFT_RA2 = 4'd9;
  localparam logic [3:0] SLTI      = 4'd10;
  localparam logic [3:0] BEQ       = 4'd11;
  localparam logic [3:0] BNE       = 4'd12;
  localparam logic [3:0] BLE       = 4'd13;
  localparam logic [3:0] BGT       = 4'd14;
  localparam logic [3:0] LUI       = 4'd15;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_HOLD,
    S_COMPLETE,
    S_ERR
  } state_t;

  state_t     state_q;
  logic [3:0] aluop_q;
  logic [3:0] code_q;
  logic       hold2_q;
  logic       busy_q;
  logic       done_q;
  logic       illegal_q;

  logic [3:0] dec_code;
  logic       dec_illegal;
  logic       dec_hold2;
  logic       is_branch;
  logic       in_complete;
  logic       cond_true;

  // Instruction decode of the currently presented opcode/funct.
  always_comb begin
    dec_code    = NO_OP;
    dec_illegal = 1'b0;
    if (opcode == 6'h00) begin
      case (funct)
        6'h20:   dec_code = ADD;
        6'h22:   dec_code = SUB;
        6'h24:   dec_code = AND_OP;
        6'h00:   dec_code = SHIFT_L1;
        6'h02:   dec_code = SHIFT_R;
        6'h03:   dec_code = SHIFT_RA1;
        6'h04:   dec_code = SHIFT_L2;
        6'h07:   dec_code = SHIFT_RA2;
        default: dec_illegal = 1'b1;
      endcase
    end else begin
      case (opcode)
        6'h08, 6'h23, 6'h2B: dec_code = ADD;
        6'h0A:   dec_code = SLTI;
        6'h04:   dec_code = BEQ;
        6'h05:   dec_code = BNE;
        6'h06:   dec_code = BLE;
        6'h07:   dec_code = BGT;
        6'h0F:   dec_code = LUI;
        default: dec_illegal = 1'b1;
      endcase
    end
    // Load-then-shift ops need the decoder to see the code for two cycles.
    dec_hold2 = (dec_code == SHIFT_L1) || (dec_code == SHIFT_R) ||
                (dec_code == SHIFT_RA1) || (dec_code == LUI);
  end

  // Sequencer FSM with registered ALUOp/busy/done/illegal.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      aluop_q   <= NO_OP;
      code_q    <= NO_OP;
      hold2_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      case (state_q)
        S_IDLE, S_COMPLETE, S_ERR: begin
          if (start) begin
            code_q  <= dec_code;
            hold2_q <= dec_hold2;
            if (dec_illegal) begin
              state_q   <= S_ERR;
              aluop_q   <= NO_OP;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
              illegal_q <= 1'b1;
            end else begin
              state_q <= S_ISSUE;
              aluop_q <= dec_code;
              busy_q  <= 1'b1;
            end
          end else begin
            state_q <= S_IDLE;
            aluop_q <= NO_OP;
            busy_q  <= 1'b0;
          end
        end
        S_ISSUE: begin
          if (hold2_q) begin
            state_q <= S_HOLD;
          end else begin
            state_q <= S_COMPLETE;
            aluop_q <= NO_OP;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        S_HOLD: begin
          state_q <= S_COMPLETE;
          aluop_q <= NO_OP;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        default: begin
          state_q <= S_IDLE;
          aluop_q <= NO_OP;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Completion strobes: flags and decoder feedback are only valid in COMPLETE, so they are
  // state-decoded from live inputs there rather than registered a cycle early.
  always_comb begin
    in_complete = (state_q == S_COMPLETE);
    is_branch   = (code_q >= BEQ) && (code_q <= BGT);
    case (UC_op)
      2'b00:   cond_true = zero;
      2'b01:   cond_true = ~zero;
      2'b10:   cond_true = lt | zero;
      default: cond_true = gt;
    endcase
  end

  assign ALUOp         = aluop_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign illegal       = illegal_q;
  assign proto_err     = in_complete & (UC_control != is_branch);
  assign alu_out_write = in_complete & ~is_branch & ~UC_control;
  assign branch_taken  = in_complete & is_branch & UC_control & cond_true;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomized bench for alu_op_sequencer with a per-cycle expected-output table.
// Expected outputs come from an instruction-level model indexed by cycle number.
// Directed cases pin the model with literal expectations from the ALUOp rules.
module tb_alu_op_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero, lt, gt, UC_control;
  logic [1:0] UC_op;
  logic [3:0] ALUOp;
  logic       busy, done, alu_out_write, branch_taken, illegal, proto_err;

  typedef struct packed {
    logic [3:0] aluop;
    logic       busy;
    logic       done;
    logic       aow;
    logic       bt;
    logic       ill;
    logic       pe;
  } obs_t;

  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  logic chk_en = 1'b0;
  obs_t exp_tab[int];
  obs_t obs_log[int];

  alu_op_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode), .funct(funct),
    .zero(zero), .lt(lt), .gt(gt), .UC_control(UC_control), .UC_op(UC_op),
    .ALUOp(ALUOp), .busy(busy), .done(done), .alu_out_write(alu_out_write),
    .branch_taken(branch_taken), .illegal(illegal), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", name, c, act, exp);
    end
  endtask

  // Single compare process: every cycle, DUT outputs vs the model's table (idle if no entry).
  always @(negedge clk) begin
    obs_t o;
    obs_t e;
    o = {ALUOp, busy, done, alu_out_write, branch_taken, illegal, proto_err};
    obs_log[cyc] = o;
    if (chk_en) begin
      e = exp_tab.exists(cyc) ? exp_tab[cyc] : obs_t'(0);
      check("cycle_outputs", cyc, 32'(o), 32'(e));
    end
  end

  // Instruction-level model: ALUOp code for an instruction, -1 when unsupported.
  function automatic int model_code(input logic [5:0] opc, input logic [5:0] fn);
    if (opc == 6'h00) begin
      case (fn)
        6'h20: return 1;
        6'h22: return 2;
        6'h24: return 3;
        6'h00: return 5;
        6'h02: return 7;
        6'h03: return 8;
        6'h04: return 6;
        6'h07: return 9;
        default: return -1;
      endcase
    end
    case (opc)
      6'h08, 6'h23, 6'h2B: return 1;
      6'h0A: return 10;
      6'h04: return 11;
      6'h05: return 12;
      6'h06: return 13;
      6'h07: return 14;
      6'h0F: return 15;
      default: return -1;
    endcase
  endfunction

  function automatic bit model_branch(input int code);
    return (code >= 11) && (code <= 14);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int k);
    repeat (k) begin
      start = 1'b0;
      tick();
    end
  endtask

  // Launch one instruction in the current cycle; completion flags apply only in its final cycle.
  task automatic launch(input logic [5:0] opc, input logic [5:0] fn, input logic ucc,
                        input logic [1:0] ucop, input logic z, input logic l, input logic g,
                        output int n, output int c);
    int   code;
    int   hold;
    bit   br;
    bit   cond;
    obs_t e;
    n = cyc;
    code = model_code(opc, fn);
    start = 1'b1;
    opcode = opc;
    funct = fn;
    if (code < 0) begin
      c = n + 1;
      e = '0;
      e.done = 1'b1;
      e.ill = 1'b1;
      exp_tab[c] = e;
    end else begin
      hold = (code == 5 || code == 7 || code == 8 || code == 15) ? 2 : 1;
      for (int i = 1; i <= hold; i++) begin
        e = '0;
        e.aluop = code[3:0];
        e.busy = 1'b1;
        exp_tab[n + i] = e;
      end
      c = n + hold + 1;
      br = model_branch(code);
      case (ucop)
        2'd0: cond = z;
        2'd1: cond = !z;
        2'd2: cond = l || z;
        default: cond = g;
      endcase
      e = '0;
      e.done = 1'b1;
      e.pe = (ucc != br);
      e.bt = !e.pe && br && cond;
      e.aow = !e.pe && !br;
      exp_tab[c] = e;
    end
    tick();
    while (cyc < c) begin
      // Busy cycles: start must be ignored, flags are don't-care.
      start = 1'($urandom); opcode = 6'($urandom); funct = 6'($urandom);
      zero = 1'($urandom); lt = 1'($urandom); gt = 1'($urandom);
      UC_control = 1'($urandom); UC_op = 2'($urandom);
      tick();
    end
    start = 1'b0; opcode = 6'($urandom); funct = 6'($urandom);
    zero = z; lt = l; gt = g; UC_control = ucc; UC_op = ucop;
  endtask

  logic [5:0] r_fn[8]  = '{6'h20, 6'h22, 6'h24, 6'h00, 6'h02, 6'h03, 6'h04, 6'h07};
  logic [5:0] i_opc[9] = '{6'h08, 6'h23, 6'h2B, 6'h0A, 6'h04, 6'h05, 6'h06, 6'h07, 6'h0F};
  logic [5:0] b_opc[4] = '{6'h04, 6'h05, 6'h06, 6'h07};
  logic       b_z[4]   = '{1'b1, 1'b1, 1'b1, 1'b0};
  logic       b_exp[4] = '{1'b1, 1'b0, 1'b1, 1'b0};

  initial begin
    int n, c, n2, c2;
    logic [5:0] opc, fn;
    logic ucc;
    int code;
    reset = 1'b1; start = 1'b0; opcode = '0; funct = '0;
    zero = 1'b0; lt = 1'b0; gt = 1'b0; UC_control = 1'b0; UC_op = 2'd0;
    repeat (3) tick();
    check("reset_state", cyc - 1, 32'(obs_log[cyc - 1]), 32'd0);
    reset = 1'b0;
    tick();
    chk_en = 1'b1;

    // add: ALUOp=1 for one cycle, then done + alu_out_write.
    launch(6'h00, 6'h20, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, n, c);
    idle(1);
    check("add_issue_aluop", n + 1, 32'(obs_log[n + 1].aluop), 32'd1);
    check("add_busy", n + 1, 32'(obs_log[n + 1].busy), 32'd1);
    check("add_done_aow", n + 2, 32'({obs_log[n + 2].done, obs_log[n + 2].aow, obs_log[n + 2].busy}), 32'b110);

    // sll holds 2 cycles, sllv holds 1.
    launch(6'h00, 6'h00, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, n, c);
    idle(1);
    check("sll_aluop_seq", n + 1, 32'({obs_log[n + 1].aluop, obs_log[n + 2].aluop, obs_log[n + 3].aluop}), 32'h550);
    check("sll_done_t3", n + 3, 32'(obs_log[n + 3].done), 32'd1);
    launch(6'h00, 6'h04, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, n, c);
    idle(1);
    check("sllv_aluop_seq", n + 1, 32'({obs_log[n + 1].aluop, obs_log[n + 2].aluop}), 32'h60);
    check("sllv_done_t2", n + 2, 32'(obs_log[n + 2].done), 32'd1);

    // Branch resolution, UC_op follows the branch kind.
    for (int i = 0; i < 4; i++) begin
      launch(b_opc[i], 6'h00, 1'b1, 2'(i), b_z[i], 1'b0, 1'b0, n, c);
      idle(1);
      check("branch_taken", c, 32'(obs_log[c].bt), 32'(b_exp[i]));
      check("branch_pe_aow", c, 32'({obs_log[c].pe, obs_log[c].aow}), 32'd0);
    end

    // Back-to-back lui then slti.
    launch(6'h0F, 6'h00, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, n, c);
    launch(6'h0A, 6'h00, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, n2, c2);
    idle(1);
    check("b2b_aluop_seq", n + 1, 32'({obs_log[n + 1].aluop, obs_log[n + 2].aluop, obs_log[n + 3].aluop,
                                        obs_log[n + 4].aluop, obs_log[n + 5].aluop}), 32'hFF0A0);
    check("b2b_done_seq", n + 3, 32'({obs_log[n + 3].done, obs_log[n + 4].done, obs_log[n + 5].done}), 32'b101);

    // Illegal opcode and protocol error.
    launch(6'h3F, 6'h00, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, n, c);
    idle(1);
    check("illegal_t1", n + 1, 32'({obs_log[n + 1].aluop, obs_log[n + 1].ill, obs_log[n + 1].done}), 32'b000011);
    launch(6'h04, 6'h00, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, n, c);
    idle(1);
    check("proto_err_beq", c, 32'({obs_log[c].pe, obs_log[c].bt}), 32'b10);

    // Reset during HOLD of srl.
    chk_en = 1'b0;
    n = cyc;
    start = 1'b1; opcode = 6'h00; funct = 6'h02;
    tick();
    start = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    check("srl_hold_before_reset", n + 2, 32'(obs_log[n + 2].aluop), 32'd7);
    check("reset_mid_hold", n + 3, 32'(obs_log[n + 3]), 32'd0);
    check("no_done_after_reset", n + 4, 32'(obs_log[n + 4]), 32'd0);
    chk_en = 1'b1;
    launch(6'h00, 6'h20, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, n, c);
    idle(1);
    check("add_after_reset", c, 32'({obs_log[c].done, obs_log[c].aow}), 32'b11);
    check("add_after_reset_t2", c - n, 32'(c - n), 32'd2);

    // Random instruction stream, checked every cycle against the model table.
    repeat (300) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: begin opc = 6'h00; fn = r_fn[$urandom_range(0, 7)]; end
        4, 5, 6, 7: begin opc = i_opc[$urandom_range(0, 8)]; fn = 6'($urandom); end
        default: begin opc = 6'($urandom); fn = 6'($urandom); end
      endcase
      code = model_code(opc, fn);
      ucc = 1'(model_branch(code));
      if ($urandom_range(0, 9) == 0) ucc = !ucc;
      launch(opc, fn, ucc, 2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), n, c);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
